ring_johnson_counter: RTL and testbench
=======================================

RING_JOHNSON_COUNTER -- requirements
Module: ring_johnson_counter

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the register width; legal range 2..64.
REQ-002 The module SHALL have a derived localparam CW = $clog2(2*N), giving the count output width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port start, input, 1 bit: synchronous reload of the seed for the current mode.
REQ-006 Port en, input, 1 bit: step enable.
REQ-007 Port mode, input, 1 bit: 0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-008 Port dir, input, 1 bit: 0 = up, 1 = down.
REQ-009 Port qout, output, N bits [N-1:0]: counter register.
REQ-010 Port count, output, CW bits: binary phase index of qout, registered.
REQ-011 Port wrap, output, 1 bit: registered one-cycle pulse on a modulo wrap.
REQ-012 Port err, output, 1 bit: registered one-cycle pulse when an illegal state is corrected.

Function
REQ-013 Internal register mode_q SHALL hold the active mode; all decoding SHALL use mode_q, never raw mode.
REQ-014 Seed values SHALL be: ring 0...01 with count 0; Johnson 0...00 with count 0.
REQ-015 Ring up step SHALL be qout <= {qout[N-2:0], qout[N-1]}, with count <= (count+1) mod N.
REQ-016 Ring down step SHALL be qout <= {qout[0], qout[N-1:1]}, with count <= (count-1) mod N.
REQ-017 Johnson up step SHALL be qout <= {qout[N-2:0], ~qout[N-1]}, with count <= (count+1) mod 2N.
REQ-018 Johnson down step SHALL be qout <= {~qout[0], qout[N-1:1]}, with count <= (count-1) mod 2N.
REQ-019 count SHALL always equal the phase of qout:
- ring: the index of the set bit;
- Johnson: k for k low-anchored ones (k = 0..N), and 2N-j for j high-anchored ones (j = 1..N-1).
REQ-020 Legal states SHALL be exactly: ring, one-hot; Johnson, the 2N patterns of REQ-019. All other values are illegal.
REQ-021 Per-cycle priority SHALL be, highest first:
- rst_n low;
- start;
- mode != mode_q;
- illegal qout;
- en step;
- hold.
REQ-022 On start=1: qout and count SHALL load the seed for mode_q; wrap=0; err=0.
REQ-023 On mode != mode_q (and start=0): mode_q <= mode, and qout/count SHALL load the seed of the new mode; wrap=0; err=0.
REQ-024 On illegal qout (no higher-priority event): qout/count SHALL load the seed of mode_q and err SHALL be 1 for exactly that next cycle. The check is evaluated every cycle, regardless of en.
REQ-025 wrap SHALL be 1 in the cycle after a step that moves count from its last value to 0 (up) or from 0 to its last value (down); the last value is N-1 (ring) or 2N-1 (Johnson).
REQ-026 With en=0 and no higher-priority event: qout, count and mode_q SHALL hold, and wrap=0, err=0.
REQ-027 dir SHALL be sampled each enabled cycle; a direction reversal mid-sequence SHALL step from the current phase with no skip or repeat.
REQ-028 There SHALL be no combinational path from any input to any output.

Reset
REQ-029 With rst_n=0 at a rising edge, the block SHALL set: mode_q=0, qout=0...01, count=0, wrap=0, err=0.
REQ-030 Reset asserted mid-sequence SHALL override start, en and mode in the same cycle.
REQ-031 After reset, if mode=1 the first cycle SHALL perform the mode-change reload of REQ-023.
REQ-032 There SHALL be no asynchronous reset path; outputs SHALL not change between clock edges.

Verification
REQ-033 Scenario, ring up: N=4, mode=0, dir=0, en=1 for 5 cycles after reset -> qout 0010, 0100, 1000, 0001, 0010; count 1, 2, 3, 0, 1; wrap=1 only with 0001.
REQ-034 Scenario, Johnson down: N=4, mode=1, dir=1, en=1 from seed -> qout 1000, 1100, 1110, 1111, 0111; count 7, 6, 5, 4, 3; wrap=1 with the first value (1000).
REQ-035 Scenario, illegal-state recovery: force qout=0110 in ring mode with en=0 -> next cycle qout=0001, count=0, err=1; the following cycle err=0.
REQ-036 Scenario, priority: start=1 and mode toggled in the same cycle -> seed of the old mode_q; the next cycle performs the mode-change reload.
REQ-037 Scenario, reset mid-operation: rst_n=0 with en=1 and start=1 at count=2 (ring) -> qout=0001, count=0, mode_q=0.
REQ-038 Scenario, exhaustive run: N=2..8, random en/dir/mode for at least 10k cycles -> qout always legal, count always consistent per REQ-019, wrap matches a reference model.

Source files
------------

// File: rtl/ring_johnson_counter.sv
// ---------------------------------------------------------------------------
// ring_johnson_counter
//
// Purpose:
//   N-bit shift counter that runs either as a one-hot ring (N phases) or as
//   a Johnson / twisted ring (2N phases), in either direction. A binary
//   phase index is kept alongside the shift register, a one-cycle pulse
//   flags every modulo wrap, and any illegal register pattern is replaced
//   by the seed of the active mode with a one-cycle error pulse.
//
// Parameters:
//   N      register width, 2..64 (default 4)
//   CW     derived width of the phase index, $clog2(2*N)
//
// Ports:
//   clk    in   1   rising-edge clock, the only timing reference
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   reload the seed of the active mode
//   en     in   1   step enable
//   mode   in   1   requested mode: 0 ring, 1 Johnson
//   dir    in   1   step direction: 0 up, 1 down
//   qout   out  N   shift register
//   count  out  CW  binary phase index of qout (registered)
//   wrap   out  1   registered pulse after a modulo wrap
//   err    out  1   registered pulse after an illegal state was corrected
// ---------------------------------------------------------------------------
module ring_johnson_counter #(
    parameter  int N  = 4,
    localparam int CW = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          en,
    input  logic          mode,
    input  logic          dir,
    output logic [N-1:0]  qout,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          err
);

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    // One action is selected per cycle; the order of the checks in the
    // decoder below is the priority order (reset is handled in the flop).
    typedef enum logic [2:0] {
        ACT_START,
        ACT_MODE,
        ACT_FIX,
        ACT_STEP,
        ACT_HOLD
    } act_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    mode_e         r_mode_q;
    logic [N-1:0]  r_qout;
    logic [CW-1:0] r_count;
    logic          r_wrap;
    logic          r_err;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    mode_e         w_mode_req;
    logic          w_legal;
    logic [CW-1:0] w_last;
    logic [N-1:0]  w_step_q;
    logic [CW-1:0] w_step_count;
    logic          w_step_wrap;
    act_e          w_act;

    function automatic logic [N-1:0] f_seed(input mode_e m);
        logic [N-1:0] s;
        s = '0;
        if (m == MODE_RING) begin
            s[0] = 1'b1;
        end
        return s;
    endfunction

    // A Johnson pattern is a block of ones anchored at one end and zeros at
    // the other, so it has at most one 0/1 boundary between adjacent bits.
    // That covers the all-zero and all-one patterns plus 2(N-1) others,
    // exactly the 2N legal phases.
    function automatic logic f_johnson_legal(input logic [N-1:0] q);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 1; i < N; i++) begin
            if (q[i] != q[i-1]) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

    function automatic logic f_ring_legal(input logic [N-1:0] q);
        return $onehot(q);
    endfunction

    assign w_mode_req = mode_e'(mode);

    always_comb begin
        if (r_mode_q == MODE_RING) begin
            w_legal = f_ring_legal(r_qout);
            w_last  = CW'(N - 1);
        end else begin
            w_legal = f_johnson_legal(r_qout);
            w_last  = CW'(2 * N - 1);
        end
    end

    // Next register pattern for an enabled step.
    always_comb begin
        w_step_q = r_qout;
        if (r_mode_q == MODE_RING) begin
            if (dir) begin
                w_step_q = {r_qout[0], r_qout[N-1:1]};
            end else begin
                w_step_q = {r_qout[N-2:0], r_qout[N-1]};
            end
        end else begin
            if (dir) begin
                w_step_q = {~r_qout[0], r_qout[N-1:1]};
            end else begin
                w_step_q = {r_qout[N-2:0], ~r_qout[N-1]};
            end
        end
    end

    // Phase index follows the register arithmetically; wrap is raised when
    // the index crosses between its last value and zero in either direction.
    always_comb begin
        w_step_count = r_count;
        w_step_wrap  = 1'b0;
        if (!dir) begin
            if (r_count == w_last) begin
                w_step_count = '0;
                w_step_wrap  = 1'b1;
            end else begin
                w_step_count = r_count + 1'b1;
            end
        end else begin
            if (r_count == '0) begin
                w_step_count = w_last;
                w_step_wrap  = 1'b1;
            end else begin
                w_step_count = r_count - 1'b1;
            end
        end
    end

    // The legality check runs every cycle, independent of en, so a corrupt
    // register is repaired even while the counter is parked.
    always_comb begin
        if (start) begin
            w_act = ACT_START;
        end else if (w_mode_req != r_mode_q) begin
            w_act = ACT_MODE;
        end else if (!w_legal) begin
            w_act = ACT_FIX;
        end else if (en) begin
            w_act = ACT_STEP;
        end else begin
            w_act = ACT_HOLD;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode_q <= MODE_RING;
            r_qout   <= f_seed(MODE_RING);
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (w_act)
                ACT_START: begin
                    r_qout  <= f_seed(r_mode_q);
                    r_count <= '0;
                    r_wrap  <= 1'b0;
                    r_err   <= 1'b0;
                end
                ACT_MODE: begin
                    r_mode_q <= w_mode_req;
                    r_qout   <= f_seed(w_mode_req);
                    r_count  <= '0;
                    r_wrap   <= 1'b0;
                    r_err    <= 1'b0;
                end
                ACT_FIX: begin
                    r_qout  <= f_seed(r_mode_q);
                    r_count <= '0;
                    r_wrap  <= 1'b0;
                    r_err   <= 1'b1;
                end
                ACT_STEP: begin
                    r_qout  <= w_step_q;
                    r_count <= w_step_count;
                    r_wrap  <= w_step_wrap;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_wrap <= 1'b0;
                    r_err  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs come straight from flops
    // -----------------------------------------------------------------------
    assign qout  = r_qout;
    assign count = r_count;
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// ---------------------------------------------------------------------------
// tb_ring_johnson_counter
//
// Directed scenarios on an N=4 instance, plus randomized runs on instances
// with N=2..8 compared against a phase-based reference model: the model
// tracks only (mode, phase) and builds the expected register pattern from
// the phase number.
// ---------------------------------------------------------------------------
module tb_ring_johnson_counter;

    localparam int RND_CYCLES = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected register pattern for phase p of an n-bit counter.
    function automatic logic [63:0] model_q(input int n, input bit johnson, input int p);
        int j;
        if (!johnson) begin
            return 64'd1 << p;
        end
        if (p <= n) begin
            return (64'd1 << p) - 64'd1;
        end
        j = 2 * n - p;
        return ((64'd1 << j) - 64'd1) << (n - j);
    endfunction

    // -----------------------------------------------------------------------
    // Directed instance, N = 4
    // -----------------------------------------------------------------------
    logic       d_rst_n, d_start, d_en, d_mode, d_dir;
    logic [3:0] d_qout;
    logic [2:0] d_count;
    logic       d_wrap, d_err;

    ring_johnson_counter #(.N(4)) dut_d (
        .clk   (clk),
        .rst_n (d_rst_n),
        .start (d_start),
        .en    (d_en),
        .mode  (d_mode),
        .dir   (d_dir),
        .qout  (d_qout),
        .count (d_count),
        .wrap  (d_wrap),
        .err   (d_err)
    );

    task automatic cyc(input logic r, input logic s, input logic m, input logic d, input logic e,
                       input logic [3:0] eq, input logic [2:0] ec, input logic ew, input logic ee,
                       input string tag);
        @(negedge clk);
        d_rst_n = r;
        d_start = s;
        d_mode  = m;
        d_dir   = d;
        d_en    = e;
        @(posedge clk);
        #1;
        check({tag, ".qout"},  64'(d_qout),  64'(eq));
        check({tag, ".count"}, 64'(d_count), 64'(ec));
        check({tag, ".wrap"},  64'(d_wrap),  64'(ew));
        check({tag, ".err"},   64'(d_err),   64'(ee));
    endtask

    task automatic inject(input logic [3:0] bad, input logic [3:0] seed, input string tag);
        @(negedge clk);
        d_start = 1'b0;
        d_en    = 1'b0;
        force dut_d.r_qout = bad;
        #1;
        release dut_d.r_qout;
        @(posedge clk);
        #1;
        check({tag, ".qout"},  64'(d_qout),  64'(seed));
        check({tag, ".count"}, 64'(d_count), 64'd0);
        check({tag, ".err"},   64'(d_err),   64'd1);
        check({tag, ".wrap"},  64'(d_wrap),  64'd0);
    endtask

    // -----------------------------------------------------------------------
    // Randomized instances, N = 2..8
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 7; gi++) begin : g_rnd
        localparam int NN  = gi + 2;
        localparam int CWN = $clog2(2 * NN);

        logic            rst_n_g, start_g, en_g, mode_g, dir_g;
        logic [NN-1:0]   q_g;
        logic [CWN-1:0]  cnt_g;
        logic            wrap_g, err_g;
        bit              done;

        ring_johnson_counter #(.N(NN)) u_dut (
            .clk   (clk),
            .rst_n (rst_n_g),
            .start (start_g),
            .en    (en_g),
            .mode  (mode_g),
            .dir   (dir_g),
            .qout  (q_g),
            .count (cnt_g),
            .wrap  (wrap_g),
            .err   (err_g)
        );

        initial begin
            int    ph;
            int    nph;
            bit    mq;
            bit    ew;
            string tq, tc, tw, te;
            tq = $sformatf("N%0d.qout", NN);
            tc = $sformatf("N%0d.count", NN);
            tw = $sformatf("N%0d.wrap", NN);
            te = $sformatf("N%0d.err", NN);
            done    = 1'b0;
            rst_n_g = 1'b0;
            start_g = 1'b0;
            en_g    = 1'b0;
            mode_g  = 1'b0;
            dir_g   = 1'b0;
            ph      = 0;
            mq      = 1'b0;
            for (int c = 0; c < RND_CYCLES; c++) begin
                @(negedge clk);
                rst_n_g = (c < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
                start_g = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 39) == 0) begin
                    mode_g = ~mode_g;
                end
                dir_g = 1'($urandom_range(0, 1));
                en_g  = ($urandom_range(0, 3) != 0);

                ew  = 1'b0;
                nph = mq ? 2 * NN : NN;
                if (!rst_n_g) begin
                    mq = 1'b0;
                    ph = 0;
                end else if (start_g) begin
                    ph = 0;
                end else if (mode_g != mq) begin
                    mq = mode_g;
                    ph = 0;
                end else if (en_g) begin
                    if (!dir_g) begin
                        ew = (ph == nph - 1);
                        ph = (ph + 1) % nph;
                    end else begin
                        ew = (ph == 0);
                        ph = (ph + nph - 1) % nph;
                    end
                end

                @(posedge clk);
                #1;
                check(tq, 64'(q_g),    model_q(NN, mq, ph));
                check(tc, 64'(cnt_g),  64'(ph));
                check(tw, 64'(wrap_g), 64'(ew));
                check(te, 64'(err_g),  64'd0);
            end
            done = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Directed sequence and summary
    // -----------------------------------------------------------------------
    initial begin
        bit all_done;
        d_rst_n = 1'b0;
        d_start = 1'b0;
        d_en    = 1'b0;
        d_mode  = 1'b0;
        d_dir   = 1'b0;

        // reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, "rst");
        check("rst.mode_q", 64'(dut_d.r_mode_q), 64'd0);

        // ring up
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 3'd1, 1'b0, 1'b0, "ru1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 3'd2, 1'b0, 1'b0, "ru2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 3'd3, 1'b0, 1'b0, "ru3");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 3'd0, 1'b1, 1'b0, "ru4");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 3'd1, 1'b0, 1'b0, "ru5");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 3'd2, 1'b0, 1'b0, "ru6");

        // reset wins over start, en and mode
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd0, 1'b0, 1'b0, "midrst");
        check("midrst.mode_q", 64'(dut_d.r_mode_q), 64'd0);

        // mode change reload, then Johnson down from seed
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, "jmode");
        check("jmode.mode_q", 64'(dut_d.r_mode_q), 64'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 3'd7, 1'b1, 1'b0, "jd1");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 3'd6, 1'b0, 1'b0, "jd2");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1110, 3'd5, 1'b0, 1'b0, "jd3");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 3'd4, 1'b0, 1'b0, "jd4");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0111, 3'd3, 1'b0, 1'b0, "jd5");

        // start and mode toggle together: old-mode seed first, then reload
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, "prio.start");
        check("prio.start.mode_q", 64'(dut_d.r_mode_q), 64'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 3'd0, 1'b0, 1'b0, "prio.mode");
        check("prio.mode.mode_q", 64'(dut_d.r_mode_q), 64'd0);

        // illegal ring pattern with en low
        inject(4'b0110, 4'b0001, "fix.ring");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, "fix.ring.after");

        // ring down wrap, hold, and direction reversal
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 3'd3, 1'b1, 1'b0, "rd1");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 3'd3, 1'b0, 1'b0, "hold");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 3'd0, 1'b1, 1'b0, "rev1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 3'd1, 1'b0, 1'b0, "rev2");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 3'd0, 1'b0, 1'b0, "rev3");

        // illegal Johnson pattern
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, "jm2");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd1, 1'b0, 1'b0, "ju1");
        inject(4'b0101, 4'b0000, "fix.john");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, "fix.john.after");

        // wait for the randomized runs, bounded
        all_done = 1'b0;
        for (int k = 0; k < 3 * RND_CYCLES; k++) begin
            all_done = g_rnd[0].done & g_rnd[1].done & g_rnd[2].done & g_rnd[3].done &
                       g_rnd[4].done & g_rnd[5].done & g_rnd[6].done;
            if (all_done) begin
                break;
            end
            @(posedge clk);
        end
        check("rnd.done", 64'(all_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
